// File: rtl/ear_pkg.sv
// Shared constants, FSM state type and helpers for the EAR input conditioner.
package ear_pkg;

    localparam int unsigned FILTN_DEF = 8;
    localparam int unsigned PWW_DEF   = 12;
    localparam int unsigned STRW_DEF  = 16;
    localparam int unsigned FCNT_W    = 4;

    typedef enum logic {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } pw_state_e;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous pin inputs.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture, cleared to 0 while reset is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ear_filter.sv
// Cassette EAR conditioner: synchronise, glitch-filter, measure half-periods, stretch activity.
module ear_filter
    import ear_pkg::*;
#(
    parameter int unsigned FILTN = FILTN_DEF,
    parameter int unsigned PWW   = PWW_DEF,
    parameter int unsigned STRW  = STRW_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ce,
    input  logic           ear,
    input  logic           invert,
    output logic           q,
    output logic           q_edge,
    output logic [PWW-1:0] width,
    output logic           wvalid,
    output logic           active
);

    localparam logic [31:0] PW_MAX = 32'((64'd1 << PWW) - 64'd1);

    logic              sync_q;
    logic              s_c;
    logic [FCNT_W-1:0] fcnt, fcnt_nx, fcnt_inc_c;
    pw_state_e         state, state_nx;
    logic [PWW-1:0]    pw, pw_nx, pw_inc_c, width_nx;
    logic [STRW-1:0]   scnt, scnt_nx;
    logic              q_nx, edge_nx, wvalid_nx, toggle_c, pw_sat_c;

    sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (ear),
        .q     (sync_q)
    );

    // Polarity is applied after the synchroniser, so an invert flip is filtered like a real edge.
    assign s_c        = sync_q ^ invert;
    assign fcnt_inc_c = fcnt + FCNT_W'(1);
    assign pw_inc_c   = PWW'(sat_inc(32'(pw), PW_MAX));
    assign pw_sat_c   = (pw_inc_c == PWW'(PW_MAX));

    // Next-state: filter, half-period FSM and activity counter, all advancing on ce only.
    always_comb begin
        q_nx      = q;
        fcnt_nx   = fcnt;
        edge_nx   = 1'b0;
        wvalid_nx = 1'b0;
        width_nx  = width;
        state_nx  = state;
        pw_nx     = pw;
        scnt_nx   = scnt;
        toggle_c  = 1'b0;

        if (ce) begin
            if (s_c == q) begin
                fcnt_nx = '0;
            end else if (32'(fcnt_inc_c) == FILTN) begin
                fcnt_nx  = '0;
                toggle_c = 1'b1;
            end else begin
                fcnt_nx = fcnt_inc_c;
            end

            if (toggle_c) begin
                q_nx     = ~q;
                edge_nx  = 1'b1;
                pw_nx    = PWW'(1);
                state_nx = ARMED;
                scnt_nx  = '1;
                // A toggle coinciding with saturation is treated as unarmed.
                if (state == ARMED && !pw_sat_c) begin
                    width_nx  = pw;
                    wvalid_nx = 1'b1;
                end
            end else begin
                pw_nx = pw_inc_c;
                if (pw_sat_c) begin
                    state_nx = UNARMED;
                end
                if (scnt != '0) begin
                    scnt_nx = scnt - STRW'(1);
                end
            end
        end
    end

    // State and output registers; active follows scnt one clock later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q      <= 1'b0;
            fcnt   <= '0;
            q_edge <= 1'b0;
            width  <= '0;
            wvalid <= 1'b0;
            pw     <= '0;
            state  <= UNARMED;
            scnt   <= '0;
            active <= 1'b0;
        end else begin
            q      <= q_nx;
            fcnt   <= fcnt_nx;
            q_edge <= edge_nx;
            width  <= width_nx;
            wvalid <= wvalid_nx;
            pw     <= pw_nx;
            state  <= state_nx;
            scnt   <= scnt_nx;
            active <= (scnt != '0);
        end
    end

endmodule

// File: tb/tb_ear_filter.sv
// Directed bench for ear_filter: vector table plus hand sequences for stretch and reset corners.
module tb_ear_filter;

    localparam int unsigned PWW  = 8;
    localparam int unsigned STRW = 10;
    localparam int          WIN  = 1023;  // 2^STRW - 1

    logic           clock = 1'b0;
    logic           reset;
    logic           ce = 1'b0;
    logic           ear;
    logic           invert;
    logic           q;
    logic           q_edge;
    logic [PWW-1:0] width;
    logic           wvalid;
    logic           active;

    logic [2:0] phase = 3'd0;
    int         tick_cnt = 0;
    int         edge_cnt = 0;
    int         wq[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    ear_filter #(.FILTN(8), .PWW(PWW), .STRW(STRW)) dut (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .ear    (ear),
        .invert (invert),
        .q      (q),
        .q_edge (q_edge),
        .width  (width),
        .wvalid (wvalid),
        .active (active)
    );

    always #5 clock = ~clock;

    // ce one clock in eight; tick_cnt counts ce edges seen by the DUT.
    always @(posedge clock) begin
        phase <= phase + 3'd1;
        ce    <= (phase == 3'd6);
        if (ce) tick_cnt <= tick_cnt + 1;
    end

    // Collect strobes away from the active edge.
    always @(negedge clock) begin
        if (q_edge) edge_cnt++;
        if (wvalid) wq.push_back(int'(width));
    end

    typedef struct {
        logic ear;
        logic inv;
        int   ticks;
        logic exp_q;
        int   exp_edges;
        int   exp_wv;
        int   exp_width;
        logic exp_active;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic e, input logic i, input int t, input logic eq,
                                input int ee, input int ew, input int wd, input logic ea);
        vec_t v;
        v.ear = e; v.inv = i; v.ticks = t; v.exp_q = eq;
        v.exp_edges = ee; v.exp_wv = ew; v.exp_width = wd; v.exp_active = ea;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clock);
        while (!ce) @(posedge clock);
    endtask

    task automatic wait_edge(input int max_clk, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_clk; k++) begin
            @(negedge clock);
            if (q_edge) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fall(input int max_clk, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_clk; k++) begin
            @(negedge clock);
            if (!active) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  e0, w0, t0, t1;
        bit  ok;
        bit  drop;
        logic any;

        //            ear   inv   ticks q     edg wv width act
        vecs[0]  = mk(1'b1, 1'b0, 7,    1'b0, 0,  0, 0,    1'b0); // 7 samples: rejected
        vecs[1]  = mk(1'b0, 1'b0, 20,   1'b0, 0,  0, 0,    1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 8,    1'b1, 1,  0, 0,    1'b0); // toggles on last tick; active lags
        vecs[3]  = mk(1'b0, 1'b0, 171,  1'b0, 1,  1, 8,    1'b1);
        vecs[4]  = mk(1'b1, 1'b0, 171,  1'b1, 1,  1, 171,  1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 171,  1'b0, 1,  1, 171,  1'b1);
        vecs[6]  = mk(1'b1, 1'b0, 171,  1'b1, 1,  1, 171,  1'b1);
        vecs[7]  = mk(1'b0, 1'b0, 171,  1'b0, 1,  1, 171,  1'b1);
        vecs[8]  = mk(1'b0, 1'b1, 60,   1'b1, 1,  1, 171,  1'b1); // invert flip alone
        vecs[9]  = mk(1'b1, 1'b1, 60,   1'b0, 1,  1, 60,   1'b1);
        vecs[10] = mk(1'b1, 1'b1, 300,  1'b0, 0,  0, 60,   1'b1); // pw saturates
        vecs[11] = mk(1'b0, 1'b1, 100,  1'b1, 1,  0, 60,   1'b1); // re-arm only
        vecs[12] = mk(1'b1, 1'b1, 100,  1'b0, 1,  1, 100,  1'b1);
        vecs[13] = mk(1'b1, 1'b1, 1100, 1'b0, 0,  0, 100,  1'b0); // stretch expires

        // Reset held while the pin toggles.
        reset = 1'b0; ear = 1'b0; invert = 1'b0; any = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            ear = ~ear;
            any = any | q | q_edge | wvalid | active | (|width);
        end
        check("reset_hold_outputs", int'(any), 0);
        ear = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (20) wait_tick();
        @(negedge clock); #1;
        check("post_reset_q", int'(q), 0);
        check("post_reset_active", int'(active), 0);
        check("post_reset_width", int'(width), 0);
        check("post_reset_edges", edge_cnt, 0);
        check("post_reset_wvalids", wq.size(), 0);

        // Vector table, each step starting just after a ce edge.
        for (int i = 0; i < NV; i++) begin
            ear = vecs[i].ear;
            invert = vecs[i].inv;
            e0 = edge_cnt;
            w0 = wq.size();
            repeat (vecs[i].ticks) wait_tick();
            @(negedge clock); #1;
            check($sformatf("step%0d_q", i), int'(q), int'(vecs[i].exp_q));
            check($sformatf("step%0d_edges", i), edge_cnt - e0, vecs[i].exp_edges);
            check($sformatf("step%0d_wvalids", i), wq.size() - w0, vecs[i].exp_wv);
            check($sformatf("step%0d_width", i), int'(width), vecs[i].exp_width);
            check($sformatf("step%0d_active", i), int'(active), int'(vecs[i].exp_active));
        end

        // Activity stretch after a single toggle.
        ear = 1'b0;
        wait_edge(200, ok);
        check("act1_edge_seen", int'(ok), 1);
        t0 = tick_cnt;
        check("act1_lag_low", int'(active), 0);
        @(negedge clock);
        check("act1_rise", int'(active), 1);
        wait_fall((WIN + 50) * 8, ok);
        check("act1_fall_seen", int'(ok), 1);
        check("act1_window", tick_cnt - t0, WIN);

        // A toggle late in the window restarts the full window.
        ear = 1'b1;
        wait_edge(200, ok);
        check("act2_edge_seen", int'(ok), 1);
        t0 = tick_cnt;
        drop = 1'b0;
        while (tick_cnt != t0 + 892) begin
            @(negedge clock);
            if (!active) drop = 1'b1;
        end
        #1;
        ear = 1'b0;
        wait_edge(200, ok);
        check("act3_edge_seen", int'(ok), 1);
        check("act3_spacing", tick_cnt - t0, 900);
        t1 = tick_cnt;
        wait_fall((WIN + 50) * 8, ok);
        check("act3_fall_seen", int'(ok), 1);
        check("act3_window", tick_cnt - t1, WIN);
        check("act_no_dropout", int'(drop), 0);

        // Reset in the middle of a measurement.
        wait_tick();
        @(negedge clock); #1;
        ear = 1'b1;
        repeat (100) wait_tick();
        @(negedge clock); #1;
        w0 = wq.size();
        ear = 1'b0;
        repeat (200) wait_tick();
        @(negedge clock); #1;
        check("pre_rst_wvalids", wq.size() - w0, 1);
        if (wq.size() > w0) check("pre_rst_width", wq[wq.size() - 1], 100);
        reset = 1'b0;
        ear = 1'b0;
        invert = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_rst_width", int'(width), 0);
        check("mid_rst_q", int'(q), 0);
        reset = 1'b1;
        wait_tick();
        @(negedge clock); #1;
        e0 = edge_cnt;
        w0 = wq.size();
        for (int k = 0; k < 4; k++) begin
            ear = ~ear;
            repeat (60) wait_tick();
            @(negedge clock); #1;
        end
        check("post_rst_edges", edge_cnt - e0, 4);
        check("post_rst_wvalids", wq.size() - w0, 3);
        for (int j = w0; j < wq.size(); j++) begin
            check($sformatf("post_rst_width%0d", j - w0), wq[j], 60);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
